// File: rtl/updown_counter_mod.sv
// Up/down counter with programmable inclusive limit, clear, clamped load, wrap or saturate mode.
// Latency: one cycle from controls to outp/term; at_max/at_min are combinational; no backpressure.
module updown_counter_mod #(
  parameter int WIDTH     = 8,
  parameter int SATURATE  = 0,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] outp,
  output logic             at_max,
  output logic             at_min,
  output logic             term
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam bit               SAT     = (SATURATE != 0);

  logic [WIDTH-1:0] nxt;
  logic             nxt_term;
  logic             out_of_range;

  assign at_max       = (outp == max_val);
  assign at_min       = (outp == '0);
  assign out_of_range = (outp > max_val);

  // Boundary checks come before +1/-1, so the arithmetic never overflows.
  always_comb begin
    nxt      = outp;
    nxt_term = 1'b0;
    if (clr) begin
      nxt = '0;
    end else if (load) begin
      nxt = (load_val <= max_val) ? load_val : max_val;
    end else if (ena) begin
      if (out_of_range) begin
        nxt_term = 1'b1;
        nxt      = (SAT || !up) ? max_val : '0;
      end else if (up) begin
        if (at_max) begin
          nxt_term = 1'b1;
          nxt      = SAT ? outp : '0;
        end else begin
          nxt = outp + ONE;
        end
      end else begin
        if (at_min) begin
          nxt_term = 1'b1;
          nxt      = SAT ? '0 : max_val;
        end else begin
          nxt = outp - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outp <= RST_VAL;
      term <= 1'b0;
    end else begin
      outp <= nxt;
      term <= nxt_term;
    end
  end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: a wrap instance and a saturate instance share one set of inputs;
// directed vector table, a sustained-saturation sequence, then random traffic against a model.
module tb_updown_counter_mod;

  localparam int W    = 8;
  localparam int RV_W = 3;
  localparam int RV_S = 0;

  logic         clk = 1'b0;
  logic         rst, ena, up, clr, load;
  logic [W-1:0] load_val, max_val;
  logic [W-1:0] outp_w, outp_s;
  logic         at_max_w, at_min_w, term_w;
  logic         at_max_s, at_min_s, term_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  updown_counter_mod #(.WIDTH(W), .SATURATE(0), .RESET_VAL(RV_W)) u_wrap (
    .clk(clk), .rst(rst), .ena(ena), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .max_val(max_val),
    .outp(outp_w), .at_max(at_max_w), .at_min(at_min_w), .term(term_w)
  );

  updown_counter_mod #(.WIDTH(W), .SATURATE(1), .RESET_VAL(RV_S)) u_sat (
    .clk(clk), .rst(rst), .ena(ena), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .max_val(max_val),
    .outp(outp_s), .at_max(at_max_s), .at_min(at_min_s), .term(term_s)
  );

  typedef struct {
    logic r, c, l, e, u;
    int   lv, mv;
    int   ew;
    logic tw;
    int   es;
    logic ts;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic c, input logic l, input logic e,
                              input logic u, input int lv, input int mv,
                              input int ew, input logic tw, input int es, input logic ts);
    vec_t v;
    v.r = r; v.c = c; v.l = l; v.e = e; v.u = u;
    v.lv = lv; v.mv = mv;
    v.ew = ew; v.tw = tw; v.es = es; v.ts = ts;
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0d want=%0d", nm, idx, act, exp);
    end
  endtask

  // Inputs change one time unit after the rising edge, outputs are read at the same point.
  task automatic drive_step(input logic r, input logic c, input logic l, input logic e,
                            input logic u, input int lv, input int mv);
    rst = r; clr = c; load = l; ena = e; up = u;
    load_val = lv[W-1:0];
    max_val  = mv[W-1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int idx, input int mv,
                           input int ew, input logic tw, input int es, input logic ts);
    check({tag, "_outp_wrap"}, idx, int'(outp_w), ew);
    check({tag, "_term_wrap"}, idx, int'(term_w), int'(tw));
    check({tag, "_outp_sat"},  idx, int'(outp_s), es);
    check({tag, "_term_sat"},  idx, int'(term_s), int'(ts));
    check({tag, "_atmax_wrap"}, idx, int'(at_max_w), int'(ew == mv));
    check({tag, "_atmin_wrap"}, idx, int'(at_min_w), int'(ew == 0));
    check({tag, "_atmax_sat"},  idx, int'(at_max_s), int'(es == mv));
    check({tag, "_atmin_sat"},  idx, int'(at_min_s), int'(es == 0));
  endtask

  // Reference: wrap mode is modular arithmetic over 0..max, saturate mode is a clamp.
  function automatic void model(input int cur, input bit sat, input int rv,
                                input logic r, input logic c, input logic l, input logic e,
                                input logic u, input int lv, input int mv,
                                output int nx, output bit t);
    t  = 1'b0;
    nx = cur;
    if (r) nx = rv;
    else if (c) nx = 0;
    else if (l) nx = (lv < mv) ? lv : mv;
    else if (e) begin
      if (cur > mv) begin
        t  = 1'b1;
        nx = (sat || !u) ? mv : 0;
      end else if (!sat) begin
        nx = u ? (cur + 1) % (mv + 1) : (cur + mv) % (mv + 1);
        t  = u ? (cur == mv) : (cur == 0);
      end else if (u) begin
        nx = (cur + 1 > mv) ? mv : cur + 1;
        t  = (cur >= mv);
      end else begin
        nx = (cur == 0) ? 0 : cur - 1;
        t  = (cur == 0);
      end
    end
  endfunction

  initial begin
    int mw, ms, nw, ns, mv, lv;
    bit tw, ts;
    logic r, c, l, e, u;

    rst = 1'b1; clr = 1'b0; load = 1'b0; ena = 1'b0; up = 1'b0;
    load_val = '0; max_val = '0;

    //                r  c  l  e  u   lv   mv   wrap    sat
    vecs.push_back(mk(1, 1, 1, 1, 1,   5,   9,   3, 0,   0, 0)); // reset beats all
    vecs.push_back(mk(0, 1, 1, 0, 0,   5,   9,   0, 0,   0, 0)); // clr beats load
    vecs.push_back(mk(0, 0, 1, 0, 0,   7,   9,   7, 0,   7, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1,   0,   9,   8, 0,   8, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1,   0,   9,   9, 0,   9, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1,   0,   9,   0, 1,   9, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1,   0,   9,   1, 0,   9, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0,   0,   9,   0, 0,   8, 0)); // wrap down
    vecs.push_back(mk(0, 0, 0, 1, 0,   0,   9,   9, 1,   7, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0,   0,   9,   8, 0,   6, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 198, 200, 198, 0, 198, 0)); // saturate up
    vecs.push_back(mk(0, 0, 0, 1, 1,   0, 200, 199, 0, 199, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1,   0, 200, 200, 0, 200, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1,   0, 200,   0, 1, 200, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1,   0, 200,   1, 0, 200, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1,   0, 200,   2, 0, 200, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0,   1, 200,   1, 0,   1, 0)); // saturate down
    vecs.push_back(mk(0, 0, 0, 1, 0,   0, 200,   0, 0,   0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0,   0, 200, 200, 1,   0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0,  80,  50,  50, 0,  50, 0)); // load clamp
    vecs.push_back(mk(0, 0, 1, 0, 0,  40,  50,  40, 0,  40, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1,   0,  20,   0, 1,  20, 1)); // limit lowered, up
    vecs.push_back(mk(0, 0, 1, 0, 0,  40,  50,  40, 0,  40, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0,   0,  20,  20, 1,  20, 1)); // limit lowered, down
    vecs.push_back(mk(0, 0, 1, 0, 0,   3, 255,   3, 0,   3, 0)); // enable gaps
    vecs.push_back(mk(0, 0, 0, 1, 1,   0, 255,   4, 0,   4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,   0, 255,   4, 0,   4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,   0, 255,   4, 0,   4, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1,   0, 255,   5, 0,   5, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 255, 255, 255, 0, 255, 0)); // full range
    vecs.push_back(mk(0, 0, 0, 1, 1,   0, 255,   0, 1, 255, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0,   0,   0,   0, 0,   0, 0)); // zero modulus
    vecs.push_back(mk(0, 0, 0, 1, 1,   0,   0,   0, 1,   0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0,   0,   0,   0, 1,   0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,   0,   0,   0, 0,   0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1,   0, 255,   3, 0,   0, 0)); // reset value above limit
    vecs.push_back(mk(0, 0, 0, 1, 1,   0,   2,   0, 1,   1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive_step(vecs[i].r, vecs[i].c, vecs[i].l, vecs[i].e, vecs[i].u, vecs[i].lv, vecs[i].mv);
      check_all("vec", i, vecs[i].mv, vecs[i].ew, vecs[i].tw, vecs[i].es, vecs[i].ts);
    end

    // Sustained saturation: term must re-assert every cycle while ena stays high.
    drive_step(0, 0, 1, 0, 0, 5, 5);
    for (int i = 0; i < 4; i++) begin
      drive_step(0, 0, 0, 1, 1, 0, 5);
      check_all("sustain", i, 5, i, (i == 0), 5, 1'b1);
    end

    // Random traffic against the model, starting from a known reset.
    drive_step(1, 0, 0, 0, 0, 0, 255);
    mw = RV_W; ms = RV_S; mv = 255;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 63) == 0);
      c = ($urandom_range(0, 15) == 0);
      l = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) != 0);
      u = $urandom_range(0, 1);
      lv = $urandom_range(0, 255);
      if ($urandom_range(0, 15) == 0)
        mv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
      model(mw, 1'b0, RV_W, r, c, l, e, u, lv, mv, nw, tw);
      model(ms, 1'b1, RV_S, r, c, l, e, u, lv, mv, ns, ts);
      drive_step(r, c, l, e, u, lv, mv);
      mw = nw; ms = ns;
      check_all("rand", i, mv, mw, tw, ms, ts);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
Parametrised up/down counter with a programmable modulus, synchronous parallel load and clear, and a selectable wrap or saturate mode. It is the general-purpose successor to the team's fixed 3-bit up/down counter. It is used wherever a block needs an index, timer or credit count, and it provides boundary flags and a registered terminal-event pulse.

Parameters:
WIDTH, 8, counter width in bits (legal range 2..32)
SATURATE, 0, 0 = wrap at the boundaries; 1 = hold at the boundaries
RESET_VAL, 0, value loaded into outp on rst; must satisfy RESET_VAL <= 2^WIDTH-1

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, synchronous, active-high
ena  input  1  count enable; one step per cycle while high
up  input  1  direction; 1 = increment, 0 = decrement
clr  input  1  synchronous clear of outp to 0
load  input  1  synchronous parallel load
load_val  input  WIDTH  value for load
max_val  input  WIDTH  inclusive upper limit; the count range is 0..max_val
outp  output  WIDTH  current count (registered)
at_max  output  1  combinational, (outp == max_val)
at_min  output  1  combinational, (outp == 0)
term  output  1  registered one-cycle pulse on a boundary event

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: outp = RESET_VAL, term = 0. Reset overrides every other input in the same cycle.
- Priority, evaluated per rising edge: rst > clr > load > ena > hold.
- clr: outp <= 0, term <= 0.
- load:
  - if load_val <= max_val, outp <= load_val;
  - otherwise outp <= max_val (clamped).
  - term <= 0.
- ena=1, up=1, outp < max_val: outp <= outp+1, term <= 0.
- ena=1, up=1, outp == max_val:
  - SATURATE=0: outp <= 0, term <= 1.
  - SATURATE=1: outp holds, term <= 1.
- ena=1, up=0, outp > 0 and outp <= max_val: outp <= outp-1, term <= 0.
- ena=1, up=0, outp == 0:
  - SATURATE=0: outp <= max_val, term <= 1.
  - SATURATE=1: outp holds at 0, term <= 1.
- Out of range (outp > max_val, e.g. max_val lowered at runtime, or RESET_VAL > max_val) with ena=1:
  - SATURATE=0: up gives outp <= 0, down gives outp <= max_val; term <= 1 in both cases.
  - SATURATE=1: outp <= max_val in either direction, term <= 1.
- ena=0 with no clr/load: outp holds, term <= 0.
- term timing:
  - Asserted in the cycle after the boundary step, for one cycle.
  - Sustained saturation with ena held high re-asserts term every cycle.
- Degenerate modulus max_val == 0:
  - outp stays 0.
  - Every enabled step is a boundary event, so term <= 1 on each one.
  - at_max = at_min = 1.
- Arithmetic:
  - Computed at WIDTH bits.
  - No internal overflow is possible, because the boundary checks precede the +1/-1.
  - max_val = 2^WIDTH-1 gives a full natural-width counter.
- Input timing:
  - max_val is sampled every cycle and is not registered.
  - at_max and at_min follow outp and max_val combinationally, with zero latency.
- Latency: one cycle from a control input to outp; term is coincident with the updated outp.

Test Plan:
- Reset and priority: assert rst with clr, load and ena all high -> next cycle outp=RESET_VAL, term=0. Then clr=1, load=1, load_val=5 -> outp=0.
- Wrap up: WIDTH=8, SATURATE=0, max_val=9, load 7, up=1, ena=1 for 4 cycles -> outp sequence 8, 9, 0, 1; term=1 only in the cycle outp=0; at_max=1 while outp=9.
- Wrap down: max_val=9, outp=1, up=0, ena=1 for 3 cycles -> outp 0, 9, 8; term pulses with outp=9; at_min=1 while outp=0.
- Saturate: SATURATE=1, max_val=200, load 198, up=1, ena held 5 cycles -> outp 199, 200, 200, 200, 200; term=1 on each of the last three. Then up=0 from outp=1 -> outp 0, 0; term=1 on the second.
- Load clamp and runtime modulus change:
  - max_val=50, load_val=80 -> outp=50.
  - With outp=40, lower max_val to 20 and set ena=1, up=1 -> outp=0 (wrap) or 20 (saturate), term=1.
- Hold and enable gaps: toggle ena 1,0,0,1 with up=1 from outp=3, max_val=255 -> outp 4, 4, 4, 5; term stays 0; full-range check with max_val=255: 255 -> 0 with term=1.
